// File: rtl/sram_addr_ctrl_pkg.sv
// Shared definitions for the AVR-to-SRAM address/strobe stage and its data mover.
//   state_e      : controller state encoding (3-bit)
//   ADDR_BYTES   : number of address bytes the AVR loads
//   ptr_advance  : byte pointer step with wrap after the last address byte
package sram_addr_ctrl_pkg;

  localparam int unsigned ADDR_BYTES = 3;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MAX_AWIDTH = ADDR_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    WR_ADDR = 3'b001,
    WR_DATA = 3'b010,
    RD_DATA = 3'b011,
    INC     = 3'b100
  } state_e;

  // Step the address byte pointer 0 -> 1 -> 2 -> 0.
  function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(ADDR_BYTES - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/sram_addr_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous control bit.
//   clk    : destination clock
//   rst_n  : async active-low reset; both flops load RST_VAL
//   d      : asynchronous input
//   q      : synchronized output (registered)
module sram_addr_ctrl_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sram_addr_ctrl.sv
// SRAM address holder and strobe forwarder between the AVR 8-bit bus and the data mover.
// The AVR loads the address bytewise through the address port (avr_sel=1); data-port
// strobes (avr_sel=0) are forwarded as bus_we_n/bus_oe_n and, optionally, bump the
// address once the access completes.
//   clk        : system clock
//   reset      : async active-low reset
//   avr_we_n   : AVR write strobe (async, active low)
//   avr_oe_n   : AVR read strobe (async, active low)
//   avr_sel    : 1 = address port, 0 = data port (async)
//   avr_data   : AVR data bus tap, sampled when an address write completes
//   sram_addr  : current SRAM address
//   bus_we_n   : write strobe to the data mover, low while in WR_DATA
//   bus_oe_n   : read strobe to the data mover, low while in RD_DATA
//   byte_ptr   : lane index for the next address byte
//   busy       : controller not idle
module sram_addr_ctrl
  import sram_addr_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH   = 19,
  parameter bit          AUTO_INC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avr_we_n,
  input  logic              avr_oe_n,
  input  logic              avr_sel,
  input  logic [BYTE_W-1:0] avr_data,
  output logic [AWIDTH-1:0] sram_addr,
  output logic              bus_we_n,
  output logic              bus_oe_n,
  output logic [PTR_W-1:0]  byte_ptr,
  output logic              busy
);

  // Synchronized strobes; strobes idle high, select idles on the data port.
  logic we_s;
  logic oe_s;
  logic sel_s;

  sram_addr_ctrl_sync2 #(.RST_VAL(1'b1)) u_sync_we (
    .clk   (clk),
    .rst_n (reset),
    .d     (avr_we_n),
    .q     (we_s)
  );

  sram_addr_ctrl_sync2 #(.RST_VAL(1'b1)) u_sync_oe (
    .clk   (clk),
    .rst_n (reset),
    .d     (avr_oe_n),
    .q     (oe_s)
  );

  sram_addr_ctrl_sync2 #(.RST_VAL(1'b0)) u_sync_sel (
    .clk   (clk),
    .rst_n (reset),
    .d     (avr_sel),
    .q     (sel_s)
  );

  state_e              state_q,     state_d;
  logic [AWIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [PTR_W-1:0]    byte_ptr_q,  byte_ptr_d;
  logic                sel_prev_q,  sel_prev_d;
  logic                bus_we_n_q,  bus_we_n_d;
  logic                bus_oe_n_q,  bus_oe_n_d;
  logic                busy_q,      busy_d;

  logic                sel_rise;
  logic                addr_store;

  // Next-state, address/pointer update and registered-output decode.
  always_comb begin
    state_d     = state_q;
    sram_addr_d = sram_addr_q;
    byte_ptr_d  = byte_ptr_q;
    sel_prev_d  = sel_s;
    addr_store  = 1'b0;
    sel_rise    = sel_s & ~sel_prev_q;

    unique case (state_q)
      IDLE: begin
        // Select is only looked at here; write wins over read.
        if (!we_s) begin
          state_d = sel_s ? WR_ADDR : WR_DATA;
        end else if (!oe_s && !sel_s) begin
          state_d = RD_DATA;
        end
      end
      WR_ADDR: begin
        if (we_s) begin
          addr_store = 1'b1;
          state_d    = IDLE;
        end
      end
      WR_DATA: begin
        if (we_s) begin
          state_d = AUTO_INC ? INC : IDLE;
        end
      end
      RD_DATA: begin
        if (oe_s) begin
          state_d = AUTO_INC ? INC : IDLE;
        end
      end
      INC: begin
        sram_addr_d = sram_addr_q + AWIDTH'(1);
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Drop the byte into its lane; bits at or above AWIDTH are discarded.
    if (addr_store) begin
      for (int unsigned i = 0; i < AWIDTH; i++) begin
        if (PTR_W'(i / BYTE_W) == byte_ptr_q) begin
          sram_addr_d[i] = avr_data[3'(i % BYTE_W)];
        end
      end
      byte_ptr_d = ptr_advance(byte_ptr_q);
    end

    // A fresh address-port select restarts the sequence; it overrides the advance.
    if (sel_rise) begin
      byte_ptr_d = '0;
    end

    bus_we_n_d = (state_d != WR_DATA);
    bus_oe_n_d = (state_d != RD_DATA);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sram_addr_q <= '0;
      byte_ptr_q  <= '0;
      sel_prev_q  <= 1'b0;
      bus_we_n_q  <= 1'b1;
      bus_oe_n_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sram_addr_q <= sram_addr_d;
      byte_ptr_q  <= byte_ptr_d;
      sel_prev_q  <= sel_prev_d;
      bus_we_n_q  <= bus_we_n_d;
      bus_oe_n_q  <= bus_oe_n_d;
      busy_q      <= busy_d;
    end
  end

  assign sram_addr = sram_addr_q;
  assign byte_ptr  = byte_ptr_q;
  assign bus_we_n  = bus_we_n_q;
  assign bus_oe_n  = bus_oe_n_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sram_addr_ctrl.sv
// Directed bench for sram_addr_ctrl (AWIDTH=19, AUTO_INC=1).
module tb_sram_addr_ctrl;

  localparam int unsigned AW = 19;

  logic          clk;
  logic          reset;
  logic          avr_we_n;
  logic          avr_oe_n;
  logic          avr_sel;
  logic [7:0]    avr_data;
  logic [AW-1:0] sram_addr;
  logic          bus_we_n;
  logic          bus_oe_n;
  logic [1:0]    byte_ptr;
  logic          busy;

  int vectors;
  int miscompares;

  sram_addr_ctrl #(.AWIDTH(AW), .AUTO_INC(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .avr_we_n  (avr_we_n),
    .avr_oe_n  (avr_oe_n),
    .avr_sel   (avr_sel),
    .avr_data  (avr_data),
    .sram_addr (sram_addr),
    .bus_we_n  (bus_we_n),
    .bus_oe_n  (bus_oe_n),
    .byte_ptr  (byte_ptr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One address-port byte write with data held well past the strobe rise.
  task automatic wr_addr(input logic [7:0] b);
    avr_data = b;
    avr_we_n = 1'b0;
    tick(4);
    chk("addr_wr_no_bus_we", 32'(bus_we_n), 32'h1);
    avr_we_n = 1'b1;
    tick(4);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b0;
    avr_we_n = 1'b1;
    avr_oe_n = 1'b1;
    avr_sel  = 1'b0;
    avr_data = 8'h00;
    tick(3);
    chk("rst_addr",  32'(sram_addr), 32'h0);
    chk("rst_ptr",   32'(byte_ptr),  32'h0);
    chk("rst_we",    32'(bus_we_n),  32'h1);
    chk("rst_oe",    32'(bus_oe_n),  32'h1);
    chk("rst_busy",  32'(busy),      32'h0);
    reset = 1'b1;
    tick(3);

    // Address load: 0x34, 0x12, 0xFF -> 0x71234 with bits 23:19 dropped.
    avr_sel = 1'b1;
    tick(3);
    wr_addr(8'h34);
    chk("load_ptr1", 32'(byte_ptr), 32'h1);
    wr_addr(8'h12);
    chk("load_ptr2", 32'(byte_ptr), 32'h2);
    wr_addr(8'hFF);
    chk("load_addr", 32'(sram_addr), 32'h71234);
    chk("load_ptr0", 32'(byte_ptr), 32'h0);
    chk("load_idle", 32'(busy), 32'h0);

    // Load 0x00010, then a 5-clock data write.
    wr_addr(8'h10);
    wr_addr(8'h00);
    wr_addr(8'h00);
    chk("load_0x10", 32'(sram_addr), 32'h10);
    avr_sel = 1'b0;
    tick(3);
    avr_we_n = 1'b0;
    tick(1);
    chk("wr_lat_e1", 32'(bus_we_n), 32'h1);
    tick(1);
    chk("wr_lat_e2", 32'(bus_we_n), 32'h1);
    tick(1);
    chk("wr_lat_e3", 32'(bus_we_n), 32'h0);
    chk("wr_busy",   32'(busy),     32'h1);
    tick(2);
    chk("wr_mid_we",   32'(bus_we_n),  32'h0);
    chk("wr_mid_addr", 32'(sram_addr), 32'h10);
    avr_we_n = 1'b1;
    tick(2);
    chk("wr_tail_we", 32'(bus_we_n), 32'h0);
    tick(1);
    chk("wr_rise_we",   32'(bus_we_n),  32'h1);
    chk("wr_rise_addr", 32'(sram_addr), 32'h10);
    tick(1);
    chk("wr_inc_addr", 32'(sram_addr), 32'h11);
    chk("wr_inc_busy", 32'(busy),      32'h0);

    // Wrap: 0x7FFFF then a read -> 0.
    avr_sel = 1'b1;
    tick(3);
    wr_addr(8'hFF);
    wr_addr(8'hFF);
    wr_addr(8'hFF);
    chk("wrap_load", 32'(sram_addr), 32'h7FFFF);
    avr_sel = 1'b0;
    tick(3);
    avr_oe_n = 1'b0;
    tick(3);
    chk("rd_oe_low", 32'(bus_oe_n), 32'h0);
    chk("rd_we_hi",  32'(bus_we_n), 32'h1);
    avr_oe_n = 1'b1;
    tick(3);
    chk("rd_oe_rise", 32'(bus_oe_n),  32'h1);
    chk("rd_hold",    32'(sram_addr), 32'h7FFFF);
    tick(1);
    chk("wrap_zero", 32'(sram_addr), 32'h0);

    // Simultaneous we/oe: write wins.
    tick(2);
    avr_we_n = 1'b0;
    avr_oe_n = 1'b0;
    tick(3);
    chk("prio_we", 32'(bus_we_n), 32'h0);
    chk("prio_oe", 32'(bus_oe_n), 32'h1);
    avr_we_n = 1'b1;
    avr_oe_n = 1'b1;
    tick(3);
    chk("prio_oe_after", 32'(bus_oe_n), 32'h1);
    tick(1);
    chk("prio_inc", 32'(sram_addr), 32'h1);
    tick(2);

    // Read on the address port is ignored.
    avr_sel = 1'b1;
    tick(3);
    avr_oe_n = 1'b0;
    tick(4);
    chk("unsup_oe",   32'(bus_oe_n), 32'h1);
    chk("unsup_busy", 32'(busy),     32'h0);
    avr_oe_n = 1'b1;
    tick(3);
    chk("unsup_addr", 32'(sram_addr), 32'h1);

    // Pointer restart via select toggle.
    wr_addr(8'h55);
    chk("rs_ptr1", 32'(byte_ptr),  32'h1);
    chk("rs_addr", 32'(sram_addr), 32'h55);
    avr_sel = 1'b0;
    tick(3);
    avr_sel = 1'b1;
    tick(3);
    chk("rs_ptr0", 32'(byte_ptr), 32'h0);
    wr_addr(8'hAA);
    chk("rs_lane0",  32'(sram_addr), 32'hAA);
    chk("rs_ptr1b",  32'(byte_ptr),  32'h1);

    // Reset mid-strobe, strobe kept low across release.
    avr_sel = 1'b0;
    tick(3);
    avr_we_n = 1'b0;
    tick(4);
    chk("mid_we_low", 32'(bus_we_n), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_we",   32'(bus_we_n),  32'h1);
    chk("async_busy", 32'(busy),      32'h0);
    chk("async_addr", 32'(sram_addr), 32'h0);
    chk("async_ptr",  32'(byte_ptr),  32'h0);
    tick(2);
    reset = 1'b1;
    tick(2);
    chk("rel_we_e2", 32'(bus_we_n), 32'h1);
    tick(1);
    chk("rel_we_e3", 32'(bus_we_n), 32'h0);
    avr_we_n = 1'b1;
    tick(4);
    chk("rel_inc", 32'(sram_addr), 32'h1);
    chk("rel_idle", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
